// File: rtl/pkt_ingress_router.sv
// Ingress parser: strips SOF and address, routes payload plus delimiter into the
// output FIFO whose address matches, with backpressure and length truncation.
module pkt_ingress_router #(
    parameter int unsigned W_WIDTH = 8,
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [W_WIDTH-1:0]           data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_PORTS*W_WIDTH-1:0]   port_addr,
    input  logic [N_PORTS-1:0]           fifo_full,
    output logic [N_PORTS-1:0]           wr_en,
    output logic [W_WIDTH-1:0]           fifo_wdata,
    output logic                         busy,
    output logic                         pkt_done,
    output logic                         pkt_drop,
    output logic [7:0]                   drop_cnt
);

    localparam int unsigned SelW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [W_WIDTH-1:0] Sof   = W_WIDTH'(8'hFF);
    localparam logic [W_WIDTH-1:0] Delim = W_WIDTH'(8'h55);
    localparam logic [7:0]         MaxLen = 8'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StGetAddr, StPayload, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [7:0]        len_q, len_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              accept;
    logic              match_found;
    logic [SelW-1:0]   match_idx;

    // Descending scan so the lowest matching index wins on duplicate addresses.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
            if (port_addr[i*W_WIDTH +: W_WIDTH] == data_in) begin
                match_found = 1'b1;
                match_idx   = SelW'(i);
            end
        end
    end

    assign in_ready = (state_q == StPayload) ? !fifo_full[sel_q] : 1'b1;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        wr_en      = '0;
        fifo_wdata = data_in;
        unique case (state_q)
            StIdle: begin
                if (accept && data_in == Sof) begin
                    state_d = StGetAddr;
                end
            end
            StGetAddr: begin
                if (accept) begin
                    if (match_found) begin
                        sel_d   = match_idx;
                        len_d   = 8'd0;
                        state_d = StPayload;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = StDiscard;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    wr_en[sel_q] = 1'b1;
                    if (data_in == Delim) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (len_q < MaxLen) begin
                        len_d = len_q + 8'd1;
                    end else begin
                        // Overlong packet: close it cleanly in the FIFO, drop the rest.
                        fifo_wdata = Delim;
                        drop_d     = 1'b1;
                        state_d    = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (accept && data_in == Delim) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = (drop_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            len_q   <= 8'd0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign pkt_done = done_q;
    assign pkt_drop = drop_q;
    assign drop_cnt = cnt_q;

endmodule
